multicycle_control_fsm: RTL and testbench

- Parametrised successor to the multicycle Control FSM.
- Same state encoding and instruction routes. Adds:
  - configurable memory latency on memory-access states,
  - a pipeline stall input,
  - an opcode latch, so decode no longer follows a live opcode,
  - instruction-complete and memory-enable strobes.
- Sits between the instruction register and the datapath control decoder; the datapath decodes `state`.

---
 rtl/multicycle_control_fsm.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM: sequences IF/RF/execute/memory states and latches the opcode in flight.
// Latency: memory states (IF, LOAD4, STORE4) last MEM_LATENCY cycles, all others one cycle; outputs follow state.
// Backpressure: stall=1 freezes state, wait counter and opcode latch; rst overrides stall.
// Optional feature macro: CONTROL_ILLEGAL_TRAP_EN (undefined opcode enters a sticky TRAP state).
module multicycle_control_fsm #(
  parameter int OPCODE_W    = 6,
  parameter int STATE_W     = 4,  // must be >= 4
  parameter int MEM_LATENCY = 1   // 1..15; 1 reproduces the legacy timing
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  output logic [STATE_W-1:0]  state,
  output logic [OPCODE_W-1:0] op_q,
  output logic                mem_en,
  output logic                instr_done,
  output logic                trap
);

  // Instruction set encodings
  localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(6'h01);
  localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6'h02);
  localparam logic [OPCODE_W-1:0] OP_AND  = OPCODE_W'(6'h03);
  localparam logic [OPCODE_W-1:0] OP_OR   = OPCODE_W'(6'h04);
  localparam logic [OPCODE_W-1:0] OP_XOR  = OPCODE_W'(6'h05);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'h09);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'h0A);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'h0B);
  localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(6'h10);
  localparam logic [OPCODE_W-1:0] OP_STR  = OPCODE_W'(6'h11);
  localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(6'h12);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'h18);
  localparam logic [OPCODE_W-1:0] OP_JUMP = OPCODE_W'(6'h1C);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_RF       = 4'd1,
    S_IMM_INJ2 = 4'd2,
    S_ALU_R3   = 4'd3,
    S_ALU_RI3  = 4'd4,
    S_ALU_4    = 4'd5,
    S_BRANCH3  = 4'd6,
    S_MEM_REF3 = 4'd7,
    S_LOAD4    = 4'd8,
    S_STORE4   = 4'd9,
    S_LOAD5    = 4'd10,
    S_JUMP3    = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t                state_q, state_d, nxt;
  logic [3:0]            cnt_q, cnt_d;
  logic [OPCODE_W-1:0]   opc_q, opc_d;
  logic                  cnt_last;
  logic                  done_raw;
  logic                  mem_st;

  function automatic logic is_rtype(input logic [OPCODE_W-1:0] o);
    return (o == OP_ADD) || (o == OP_SUB) || (o == OP_AND) || (o == OP_OR) || (o == OP_XOR);
  endfunction

  function automatic logic is_itype(input logic [OPCODE_W-1:0] o);
    return (o == OP_ADDI) || (o == OP_ANDI) || (o == OP_ORI);
  endfunction

  function automatic logic is_defined(input logic [OPCODE_W-1:0] o);
    return is_rtype(o) || is_itype(o) || (o == OP_LD) || (o == OP_STR) ||
           (o == OP_LDI) || (o == OP_BEQ) || (o == OP_JUMP);
  endfunction

  assign cnt_last = (cnt_q == CNT_LAST);

  // Next-state decode, output strobes and hold/advance of counter and opcode latch
  always_comb begin
    nxt      = state_q;
    done_raw = 1'b0;
    mem_st   = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    opc_d    = opc_q;

    case (state_q)
      S_IF: begin
        mem_st = 1'b1;
        if (cnt_last) begin
          // Only IF looks at the live opcode; everything later uses the latch.
          if (opcode == OP_LDI)        nxt = S_IMM_INJ2;
          else if (is_defined(opcode)) nxt = S_RF;
          else begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
            nxt = S_TRAP;
`else
            nxt = S_RF;
`endif
          end
        end
      end
      S_RF: begin
        if (is_rtype(opc_q))                          nxt = S_ALU_R3;
        else if (is_itype(opc_q))                     nxt = S_ALU_RI3;
        else if (opc_q == OP_BEQ)                     nxt = S_BRANCH3;
        else if ((opc_q == OP_LD) || (opc_q == OP_STR)) nxt = S_MEM_REF3;
        else if (opc_q == OP_JUMP)                    nxt = S_JUMP3;
        else begin
          // Undefined opcode without trapping behaves as a NOP ending here.
          nxt      = S_IF;
          done_raw = 1'b1;
        end
      end
      S_IMM_INJ2: begin
        nxt      = S_IF;
        done_raw = 1'b1;
      end
      S_ALU_R3, S_ALU_RI3: nxt = S_ALU_4;
      S_ALU_4, S_BRANCH3, S_JUMP3, S_LOAD5: begin
        nxt      = S_IF;
        done_raw = 1'b1;
      end
      S_MEM_REF3: begin
        if (opc_q == OP_LD)       nxt = S_LOAD4;
        else if (opc_q == OP_STR) nxt = S_STORE4;
        else                      nxt = S_IF;
      end
      S_LOAD4: begin
        mem_st = 1'b1;
        if (cnt_last) nxt = S_LOAD5;
      end
      S_STORE4: begin
        mem_st = 1'b1;
        if (cnt_last) begin
          nxt      = S_IF;
          done_raw = 1'b1;
        end
      end
`ifdef CONTROL_ILLEGAL_TRAP_EN
      S_TRAP: nxt = S_TRAP;  // sticky until reset
`endif
      default: nxt = S_IF;   // unreachable encodings recover to fetch
    endcase

    if (!stall) begin
      state_d = nxt;
      if (nxt != state_q) cnt_d = 4'd0;
      else if (mem_st)    cnt_d = cnt_q + 4'd1;
      else                cnt_d = 4'd0;
      if ((state_q == S_IF) && cnt_last) opc_d = opcode;
    end
  end

  // State, wait counter and opcode latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      cnt_q   <= 4'd0;
      opc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
    end
  end

  assign state      = STATE_W'(state_q);
  assign op_q       = opc_q;
  assign mem_en     = mem_st;
  assign instr_done = done_raw & ~stall & ~rst;
`ifdef CONTROL_ILLEGAL_TRAP_EN
  assign trap       = (state_q == S_TRAP);
`else
  assign trap       = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: two instances (MEM_LATENCY 1 and 3) driven in turn.
// Latency: one expected record per cycle, compared on the falling edge of that cycle.
// Backpressure: stall and reset are exercised explicitly through the directed vectors.
module tb_multicycle_control_fsm;

  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h10;
  localparam logic [5:0] OP_STR  = 6'h11;
  localparam logic [5:0] OP_LDI  = 6'h12;
  localparam logic [5:0] OP_BEQ  = 6'h18;
  localparam logic [5:0] OP_JUMP = 6'h1C;
  localparam logic [5:0] OP_BAD  = 6'h3F;

  logic       clk = 1'b0;
  logic       rst1, rst3;
  logic [5:0] opcode;
  logic       stall;

  logic [3:0] state1, state3;
  logic [5:0] opq1, opq3;
  logic       mem1, mem3, done1, done3, trap1, trap3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         d3;
    logic [3:0] st;
    logic [5:0] oq;
    logic       mem;
    logic       done;
    logic       trp;
    string      nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  multicycle_control_fsm #(.OPCODE_W(6), .STATE_W(4), .MEM_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst1), .opcode(opcode), .stall(stall),
    .state(state1), .op_q(opq1), .mem_en(mem1), .instr_done(done1), .trap(trap1)
  );

  multicycle_control_fsm #(.OPCODE_W(6), .STATE_W(4), .MEM_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst3), .opcode(opcode), .stall(stall),
    .state(state3), .op_q(opq3), .mem_en(mem3), .instr_done(done3), .trap(trap3)
  );

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input bit d3, input logic [5:0] opc, input bit st, input bit r,
                      input int es, input logic [5:0] eq, input bit em, input bit ed,
                      input bit et, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    opcode = opc;
    stall  = st;
    if (d3) rst3 = r; else rst1 = r;
    e.d3 = d3; e.st = 4'(es); e.oq = eq; e.mem = em; e.done = ed; e.trp = et; e.nm = nm;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares it with the selected instance
  initial begin
    exp_t       e;
    logic [3:0] a_st;
    logic [5:0] a_oq;
    logic       a_mem, a_done, a_trp;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.d3) begin
          a_st = state3; a_oq = opq3; a_mem = mem3; a_done = done3; a_trp = trap3;
        end else begin
          a_st = state1; a_oq = opq1; a_mem = mem1; a_done = done1; a_trp = trap1;
        end
        checks++;
        if (a_st !== e.st || a_oq !== e.oq || a_mem !== e.mem || a_done !== e.done || a_trp !== e.trp) begin
          errors++;
          $display("FAIL %s: got state=%0d op_q=%h mem_en=%b instr_done=%b trap=%b, expected state=%0d op_q=%h mem_en=%b instr_done=%b trap=%b",
                   e.nm, a_st, a_oq, a_mem, a_done, a_trp, e.st, e.oq, e.mem, e.done, e.trp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1; opcode = 6'h00; stall = 1'b0;
    repeat (2) @(posedge clk);

    // ---------------- MEM_LATENCY = 1 ----------------
    //     d3 opcode   stl rst st op_q     mem done trap
    step(0, OP_ADD,  0, 1, 0,  6'h00,  1, 0, 0, "reset_state");
    // ADD: 0,1,3,5
    step(0, OP_ADD,  0, 0, 0,  6'h00,  1, 0, 0, "add_if");
    step(0, OP_ADD,  0, 0, 1,  OP_ADD, 0, 0, 0, "add_rf");
    step(0, OP_ADD,  0, 0, 3,  OP_ADD, 0, 0, 0, "add_alu_r3");
    step(0, OP_ADD,  0, 0, 5,  OP_ADD, 0, 1, 0, "add_alu4");
    // STR with opcode switched to JUMP after IF: path still 0,1,7,9
    step(0, OP_STR,  0, 0, 0,  OP_ADD, 1, 0, 0, "str_if");
    step(0, OP_JUMP, 0, 0, 1,  OP_STR, 0, 0, 0, "str_rf");
    step(0, OP_JUMP, 0, 0, 7,  OP_STR, 0, 0, 0, "str_memref3");
    step(0, OP_JUMP, 0, 0, 9,  OP_STR, 1, 1, 0, "str_store4");
    // JUMP: 0,1,11
    step(0, OP_JUMP, 0, 0, 0,  OP_STR, 1, 0, 0, "jump_if");
    step(0, OP_JUMP, 0, 0, 1,  OP_JUMP,0, 0, 0, "jump_rf");
    step(0, OP_JUMP, 0, 0, 11, OP_JUMP,0, 1, 0, "jump_jump3");
    // LDI stalled 3 cycles in IMM_INJ2
    step(0, OP_LDI,  0, 0, 0,  OP_JUMP,1, 0, 0, "ldi_if");
    step(0, OP_ADD,  1, 0, 2,  OP_LDI, 0, 0, 0, "ldi_stall0");
    step(0, OP_ADD,  1, 0, 2,  OP_LDI, 0, 0, 0, "ldi_stall1");
    step(0, OP_ADD,  1, 0, 2,  OP_LDI, 0, 0, 0, "ldi_stall2");
    step(0, OP_ADD,  0, 0, 2,  OP_LDI, 0, 1, 0, "ldi_final");
    // Undefined opcode
    step(0, OP_BAD,  0, 0, 0,  OP_LDI, 1, 0, 0, "bad_if");
`ifdef CONTROL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      step(0, OP_ADD, 0, 0, 12, OP_BAD, 0, 0, 1, "bad_trap_hold");
    step(0, OP_ADD,  0, 1, 12, OP_BAD, 0, 0, 1, "bad_trap_rst");
`else
    step(0, OP_ADD,  0, 0, 1,  OP_BAD, 0, 1, 0, "bad_nop_rf");
    step(0, OP_ADD,  0, 1, 0,  OP_BAD, 1, 0, 0, "bad_nop_back_if");
`endif
    step(0, OP_ADD,  0, 0, 0,  6'h00,  1, 0, 0, "after_rst1");

    // ---------------- MEM_LATENCY = 3 ----------------
    rst1 = 1'b1;
    // LD: 0,0,0,1,7,8,8,8,10
    step(1, OP_LD,   0, 0, 0,  6'h00,  1, 0, 0, "ld_if0");
    step(1, OP_LD,   0, 0, 0,  6'h00,  1, 0, 0, "ld_if1");
    step(1, OP_LD,   0, 0, 0,  6'h00,  1, 0, 0, "ld_if2");
    step(1, OP_LD,   0, 0, 1,  OP_LD,  0, 0, 0, "ld_rf");
    step(1, OP_LD,   0, 0, 7,  OP_LD,  0, 0, 0, "ld_memref3");
    step(1, OP_LD,   0, 0, 8,  OP_LD,  1, 0, 0, "ld_load4_0");
    step(1, OP_LD,   0, 0, 8,  OP_LD,  1, 0, 0, "ld_load4_1");
    step(1, OP_LD,   0, 0, 8,  OP_LD,  1, 0, 0, "ld_load4_2");
    step(1, OP_LD,   0, 0, 10, OP_LD,  0, 1, 0, "ld_load5");
    // Second LD, reset with stall during LOAD4
    step(1, OP_LD,   0, 0, 0,  OP_LD,  1, 0, 0, "ld2_if0");
    step(1, OP_LD,   0, 0, 0,  OP_LD,  1, 0, 0, "ld2_if1");
    step(1, OP_LD,   0, 0, 0,  OP_LD,  1, 0, 0, "ld2_if2");
    step(1, OP_LD,   0, 0, 1,  OP_LD,  0, 0, 0, "ld2_rf");
    step(1, OP_LD,   0, 0, 7,  OP_LD,  0, 0, 0, "ld2_memref3");
    step(1, OP_LD,   0, 0, 8,  OP_LD,  1, 0, 0, "ld2_load4_0");
    step(1, OP_LD,   1, 1, 8,  OP_LD,  1, 0, 0, "ld2_rst_stall");
    // ADD after reset: IF must last full 3 cycles again
    step(1, OP_ADD,  0, 0, 0,  6'h00,  1, 0, 0, "rst_if0");
    step(1, OP_ADD,  0, 0, 0,  6'h00,  1, 0, 0, "rst_if1");
    step(1, OP_ADD,  0, 0, 0,  6'h00,  1, 0, 0, "rst_if2");
    step(1, OP_ADD,  0, 0, 1,  OP_ADD, 0, 0, 0, "add3_rf");
    step(1, OP_ADD,  0, 0, 3,  OP_ADD, 0, 0, 0, "add3_alu_r3");
    step(1, OP_ADD,  0, 0, 5,  OP_ADD, 0, 1, 0, "add3_alu4");
    // BEQ with a stall inside IF: counter must hold
    step(1, OP_BEQ,  0, 0, 0,  OP_ADD, 1, 0, 0, "beq_if0");
    step(1, OP_BEQ,  1, 0, 0,  OP_ADD, 1, 0, 0, "beq_if_stall");
    step(1, OP_BEQ,  0, 0, 0,  OP_ADD, 1, 0, 0, "beq_if1");
    step(1, OP_BEQ,  0, 0, 0,  OP_ADD, 1, 0, 0, "beq_if2");
    step(1, OP_ADD,  0, 0, 1,  OP_BEQ, 0, 0, 0, "beq_rf");
    step(1, OP_ADD,  0, 0, 6,  OP_BEQ, 0, 1, 0, "beq_branch3");
    step(1, OP_ADD,  0, 0, 0,  OP_BEQ, 1, 0, 0, "beq_back_if");

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
